// File: rtl/instruction_mem_loader_if.sv
// Instruction stream handshake into the memory loader.
// Master produces words, slave (the loader) accepts them.
interface instruction_mem_loader_if #(
  parameter int inst_len = 32
);
  logic                in_valid;
  logic [inst_len-1:0] in_data;
  logic                in_last;
  logic                in_ready;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/instruction_mem_loader.sv
// Streams 32-bit instructions into byte-wide instruction memory,
// big-endian, with optional NOP padding and CPU hold while loading.
module instruction_mem_loader #(
  parameter int                word_len = 8,
  parameter int                mem_size = 1024,
  parameter int                inst_len = 32,
  parameter bit                fill_nop = 1'b1,
  parameter logic [inst_len-1:0] NOP    = 32'hE000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instruction_mem_loader_if.slave in_s,
  output logic                wr_en,
  output logic [inst_len-1:0] wr_addr,
  output logic [word_len-1:0] wr_data,
  output logic                busy,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_count
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    FILL,
    FINISH
  } state_e;

  localparam logic [inst_len-1:0] MEM_END =
    inst_len'(mem_size);
  localparam logic [inst_len-1:0] MEM_LAST =
    inst_len'(mem_size - 1);

  state_e              state_q, state_d;
  logic [inst_len-1:0] ptr_q, ptr_d;
  logic [inst_len-1:0] word_q, word_d;
  logic                last_q, last_d;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [inst_len-1:0] ptr_n;
  logic [inst_len-1:0] src;
  logic [1:0]          sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      word_q  <= word_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ptr_n   = ptr_q + inst_len'(4);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCEPT;
          ptr_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ACCEPT: begin
        if (in_s.in_valid) begin
          word_d  = in_s.in_data;
          last_d  = in_s.in_last;
          idx_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          ptr_d = ptr_n;
          cnt_d = cnt_q + 16'd1;
          if (last_q && fill_nop && ptr_n < MEM_END)
            state_d = FILL;
          else if (last_q)
            state_d = FINISH;
          else if (ptr_n == MEM_END) begin
            state_d = FINISH;
            err_d   = 1'b1;
          end else
            state_d = ACCEPT;
        end
      end
      FILL: begin
        ptr_d = ptr_q + inst_len'(1);
        if (ptr_q == MEM_LAST)
          state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte lane: word byte index in WRITE, address phase in FILL
  always_comb begin
    src     = (state_q == FILL) ? NOP : word_q;
    sel     = (state_q == FILL) ? ptr_q[1:0] : idx_q;
    wr_data = '0;
    wr_addr = '0;
    if (state_q == WRITE || state_q == FILL) begin
      unique case (sel)
        2'd0: wr_data = src[4*word_len-1 -: word_len];
        2'd1: wr_data = src[3*word_len-1 -: word_len];
        2'd2: wr_data = src[2*word_len-1 -: word_len];
        default: wr_data = src[word_len-1 -: word_len];
      endcase
    end
    if (state_q == WRITE)
      wr_addr = ptr_q + {{(inst_len-2){1'b0}}, idx_q};
    else if (state_q == FILL)
      wr_addr = ptr_q;
  end

  assign in_s.in_ready = (state_q == ACCEPT);
  assign wr_en      = (state_q == WRITE) || (state_q == FILL);
  assign busy       = (state_q == ACCEPT) || wr_en;
  assign cpu_hold   = busy;
  assign done       = (state_q == FINISH);
  assign error      = err_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Directed bench for instruction_mem_loader: three instances
// cover plain load, NOP fill and overflow.
module tb_instruction_mem_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic v = 1'b0;
  logic l = 1'b0;
  logic [31:0] d = '0;
  int sel = 0;
  logic clr = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_mem_loader_if ifa ();
  instruction_mem_loader_if ifb ();
  instruction_mem_loader_if ifc ();

  assign ifa.in_valid = v && (sel == 0);
  assign ifb.in_valid = v && (sel == 1);
  assign ifc.in_valid = v && (sel == 2);
  assign ifa.in_data = d;
  assign ifb.in_data = d;
  assign ifc.in_data = d;
  assign ifa.in_last = l;
  assign ifb.in_last = l;
  assign ifc.in_last = l;

  logic        wen [3];
  logic [31:0] waddr [3];
  logic [7:0]  wdata [3];
  logic        busy_v [3];
  logic        hold_v [3];
  logic        done_v [3];
  logic        err_v [3];
  logic [15:0] wc_v [3];

  instruction_mem_loader #(
    .mem_size(64), .fill_nop(1'b0)
  ) u_a (
    .clk(clk), .rst(rst),
    .start(start && (sel == 0)),
    .in_s(ifa),
    .wr_en(wen[0]), .wr_addr(waddr[0]),
    .wr_data(wdata[0]), .busy(busy_v[0]),
    .cpu_hold(hold_v[0]), .done(done_v[0]),
    .error(err_v[0]), .word_count(wc_v[0])
  );

  instruction_mem_loader #(
    .mem_size(16), .fill_nop(1'b1)
  ) u_b (
    .clk(clk), .rst(rst),
    .start(start && (sel == 1)),
    .in_s(ifb),
    .wr_en(wen[1]), .wr_addr(waddr[1]),
    .wr_data(wdata[1]), .busy(busy_v[1]),
    .cpu_hold(hold_v[1]), .done(done_v[1]),
    .error(err_v[1]), .word_count(wc_v[1])
  );

  instruction_mem_loader #(
    .mem_size(8), .fill_nop(1'b0)
  ) u_c (
    .clk(clk), .rst(rst),
    .start(start && (sel == 2)),
    .in_s(ifc),
    .wr_en(wen[2]), .wr_addr(waddr[2]),
    .wr_data(wdata[2]), .busy(busy_v[2]),
    .cpu_hold(hold_v[2]), .done(done_v[2]),
    .error(err_v[2]), .word_count(wc_v[2])
  );

  logic        m_wen, m_ready, m_busy, m_hold;
  logic        m_done, m_err;
  logic [31:0] m_waddr;
  logic [7:0]  m_wdata;
  logic [15:0] m_wc;

  always_comb begin
    m_wen   = wen[sel];
    m_waddr = waddr[sel];
    m_wdata = wdata[sel];
    m_busy  = busy_v[sel];
    m_hold  = hold_v[sel];
    m_done  = done_v[sel];
    m_err   = err_v[sel];
    m_wc    = wc_v[sel];
    m_ready = (sel == 0) ? ifa.in_ready :
              (sel == 1) ? ifb.in_ready :
                           ifc.in_ready;
  end

  logic [7:0]  mem [64];
  int          wr_n, done_n, rdy_n, bad_order;
  int          cyc, lw_cyc, done_cyc;
  logic        hold_lw, hold_done, err_done;
  logic [15:0] wc_done;

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      wr_n      <= 0;
      done_n    <= 0;
      rdy_n     <= 0;
      bad_order <= 0;
      cyc       <= 0;
      lw_cyc    <= -10;
      done_cyc  <= -20;
      hold_lw   <= 1'b0;
      hold_done <= 1'b1;
      err_done  <= 1'b0;
      wc_done   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_wen) begin
        if (m_waddr != wr_n) bad_order <= bad_order + 1;
        mem[m_waddr[5:0]] <= m_wdata;
        wr_n    <= wr_n + 1;
        lw_cyc  <= cyc;
        hold_lw <= m_hold;
      end
      if (m_done) begin
        done_n    <= done_n + 1;
        done_cyc  <= cyc;
        hold_done <= m_hold;
        err_done  <= m_err;
        wc_done   <= m_wc;
      end
      if (m_ready) rdy_n <= rdy_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w,
                      input logic lst,
                      input int gap,
                      output int waits);
    logic hs;
    hs = 1'b0;
    waits = 0;
    repeat (gap) tick();
    v = 1'b1;
    d = w;
    l = lst;
    while (!hs && waits < 20) begin
      hs = m_ready;
      tick();
      waits++;
    end
    v = 1'b0;
    chk("accept", hs, 1'b1);
  endtask

  task automatic wait_done(input int lim);
    int k;
    int base;
    k = 0;
    base = done_n;
    while (done_n == base && k < lim) begin
      tick();
      k++;
    end
    chk("done_seen", done_n != base, 1'b1);
  endtask

  function automatic logic [127:0] img(input int n);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[119:0], mem[i]};
    return r;
  endfunction

  int w;

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_ctl",
        {m_ready, m_wen, m_busy, m_hold, m_done, m_err},
        6'b0);
    chk("rst_addr", m_waddr, 32'h0);
    chk("rst_data", m_wdata, 8'h0);
    chk("rst_wc", m_wc, 16'h0);

    // basic load, valid held back-to-back
    sel = 0;
    clear();
    go();
    chk("accept_ctl", {m_ready, m_busy, m_hold}, 3'b111);
    send(32'hE3A00014, 1'b0, 0, w);
    chk("wait_w0", w, 1);
    v = 1'b1;
    send(32'hE3A01A01, 1'b0, 0, w);
    chk("wait_w1", w, 5);
    v = 1'b1;
    send(32'hEAFFFFFF, 1'b1, 0, w);
    chk("wait_w2", w, 5);
    wait_done(20);
    chk("b_writes", wr_n, 12);
    chk("b_order", bad_order, 0);
    chk("b_addr0", mem[0], 8'hE3);
    chk("b_addr3", mem[3], 8'h14);
    chk("b_addr11", mem[11], 8'hFF);
    chk("b_image", img(12),
        {32'hE3A00014, 32'hE3A01A01, 32'hEAFFFFFF});
    chk("b_done_lat", done_cyc - lw_cyc, 1);
    chk("b_hold", {hold_lw, hold_done}, 2'b10);
    chk("b_wc", wc_done, 16'd3);
    chk("b_err", err_done, 1'b0);
    tick();
    tick();
    chk("b_pulse", done_n, 1);
    chk("b_idle", {m_busy, m_hold, m_done}, 3'b000);

    // reset during WRITE after byte 1
    clear();
    go();
    send(32'hE3A00014, 1'b0, 0, w);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_ctl",
        {m_ready, m_wen, m_busy, m_hold, m_done, m_err},
        6'b0);
    chk("mr_addr", {m_waddr, m_wdata, m_wc}, 56'h0);
    rst = 1'b0;
    chk("mr_bytes", wr_n, 2);

    // reload with random valid gaps
    clear();
    go();
    send(32'hE3A00014, 1'b0, $urandom_range(0, 3), w);
    send(32'hE3A01A01, 1'b0, $urandom_range(0, 3), w);
    send(32'hEAFFFFFF, 1'b1, $urandom_range(0, 3), w);
    wait_done(20);
    chk("g_order", bad_order, 0);
    chk("g_image", img(12),
        {32'hE3A00014, 32'hE3A01A01, 32'hEAFFFFFF});
    chk("g_wc", wc_done, 16'd3);

    // NOP fill with stray start pulses
    sel = 1;
    clear();
    go();
    send(32'hE3A00014, 1'b1, 0, w);
    for (int k = 0; k < 40 && done_n == 0; k++) begin
      start = (k == 2) || (k == 10);
      tick();
    end
    start = 1'b0;
    chk("f_done", done_n, 1);
    chk("f_writes", wr_n, 16);
    chk("f_order", bad_order, 0);
    chk("f_image", img(16),
        {32'hE3A00014, 32'hE0000000,
         32'hE0000000, 32'hE0000000});
    chk("f_wc", wc_done, 16'd1);
    tick();
    tick();
    chk("f_idle", {m_busy, m_wen, done_n}, {2'b00, 32'd1});

    // overflow, third word offered but never taken
    sel = 2;
    clear();
    go();
    send(32'h11223344, 1'b0, 0, w);
    send(32'h55667788, 1'b0, 0, w);
    v = 1'b1;
    d = 32'h99AABBCC;
    l = 1'b0;
    wait_done(20);
    chk("o_writes", wr_n, 8);
    chk("o_image", img(8), {32'h11223344, 32'h55667788});
    chk("o_err", err_done, 1'b1);
    chk("o_wc", wc_done, 16'd2);
    chk("o_ready", rdy_n, 2);
    tick();
    tick();
    chk("o_sticky", {m_err, m_ready, wr_n}, {2'b10, 32'd8});
    v = 1'b0;
    go();
    chk("o_clear", {m_err, m_ready, m_wc}, {2'b01, 16'h0});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_mem_loader.md
# instruction_mem_loader

Sequential writer that fills the byte-addressed instruction memory from a 32-bit instruction stream, so programs no longer have to be hard-coded in the memory's initial block. It accepts one instruction per valid/ready handshake and writes it big-endian as four byte writes: bits 31:24 go to addr, bits 7:0 go to addr+3. It can optionally pad the rest of memory with NOP, and it holds the processor while loading. It sits between the host/test stream and the write port of the instruction memory.

## Interface
- word_len, 8: memory word (byte) width.
- mem_size, 1024: memory size in bytes; must be a multiple of 4.
- inst_len, 32: instruction and address width.
- fill_nop, 1: when 1, pad from the end of the program to mem_size-1 with NOP.
- NOP, 32'hE000_0000: pad pattern.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a load session; sampled only in IDLE.
- in_valid  in  1  in_data/in_last valid.
- in_data  in  inst_len  instruction word.
- in_last  in  1  marks the final instruction of the program.
- in_ready  out  1  loader can accept a word.
- wr_en  out  1  byte write strobe to the instruction memory.
- wr_addr  out  inst_len  byte address.
- wr_data  out  word_len  byte to write.
- busy  out  1  session in progress.
- cpu_hold  out  1  keep the processor stalled/reset.
- done  out  1  one-cycle pulse when the session ends.
- error  out  1  overflow flag; sticky until the next start or rst.
- word_count  out  16  instructions written in the current/last session.

## Operation
- States: IDLE, ACCEPT, WRITE, FILL, FINISH.
- IDLE: in_ready=0, busy=0. start=1 moves to ACCEPT, clears ptr, word_count and error, and sets busy and cpu_hold.
- ACCEPT:
  - in_ready=1, decoded from the state register only; there is no combinational path from in_valid to in_ready.
  - On in_valid & in_ready: latch in_data and in_last, set byte_idx=0, go to WRITE.
- WRITE:
  - wr_en=1 for exactly 4 consecutive cycles.
  - wr_addr=ptr+byte_idx.
  - wr_data = latched word byte, taken as [31:24], [23:16], [15:8], [7:0] in order.
  - After the byte_idx=3 cycle: ptr+=4 and word_count+=1. Next state:
    - last=1 and fill_nop=1 and ptr<mem_size → FILL.
    - last=1 otherwise → FINISH.
    - last=0 and ptr==mem_size → FINISH with error=1.
    - otherwise → ACCEPT.
- FILL: one NOP byte per cycle at ptr (pattern E0,00,00,00 repeating, chosen by ptr[1:0]); ptr+=1; after the byte at mem_size-1, go to FINISH. word_count does not change during FILL.
- FINISH: done=1 for one cycle; cpu_hold and busy drop in the same cycle; go to IDLE.
- start outside IDLE is ignored. in_valid outside ACCEPT is ignored, and the producer must hold the word until it is accepted.
- in_last on a word that exactly fills memory: no error; FILL is skipped.
- ptr arithmetic is inst_len wide and never wraps, because the overflow check stops the session first.

## Timing
- Reset values: in_ready, wr_en, busy, cpu_hold, done and error are 0; wr_addr, wr_data and word_count are 0; state is IDLE.
- rst during any state returns to reset values on the next edge. Bytes already written stay in memory; a partially written word is not rolled back.
- start at edge N puts ACCEPT with in_ready=1 at N+1.
- Handshake at edge N: wr_en is high on cycles N+1..N+4 and in_ready is 0 in those cycles. The earliest next accept is N+5, so peak throughput is 1 word per 5 cycles.
- done rises in the cycle after the last write (byte or fill) and lasts one cycle; word_count is final by then.
- Outputs are registered or state-decoded; no input reaches an output combinationally.

## Test plan
- Basic load (fill_nop=0): words E3A00014, E3A01A01, EAFFFFFF(last).
  - Exactly 12 writes, addr 0..11.
  - addr0=E3, addr3=14, addr11=FF.
  - done one cycle after the addr-11 write; word_count=3; cpu_hold 1→0 with done.
- Backpressure: in_valid held high for 3 back-to-back words. in_ready pattern is 1,0,0,0,0 repeating, with no duplicated or dropped words; random 0–3 cycle valid gaps give the same memory image.
- Fill (mem_size=16, fill_nop=1): one word E3A00014 with last. Bytes 4..15 are E0,00,00,00 repeated; 16 writes in total; word_count=1.
- Overflow (mem_size=8): three words, none with last.
  - 8 writes, then error=1 with done.
  - The third word is never accepted; error is cleared by the next start.
- Reset mid-WRITE: rst asserted after byte 1 of word 0. wr_en is 0 and all outputs are at reset values on the next cycle; a fresh start reloads from addr 0.
- start pulsed during WRITE and FILL is ignored: ptr, word_count and the write sequence are unchanged.
